imem_boot_loader: RTL and testbench
===================================

IMEM_BOOT_LOADER -- requirements
Module: imem_boot_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, giving instruction memory depth in 32-bit words (power of two).
REQ-002 The block SHALL have parameter AW, default 8, equal to log2(DEPTH), giving the word-index width.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  is the synchronous active-high reset.
REQ-006 Port load_valid  input  1  is high when the program source presents a word.
REQ-007 Port load_data  input  32  is the instruction word to store.
REQ-008 Port load_last  input  1  is high when the presented word is the final program word.
REQ-009 Port load_ready  output  1  is high when the block accepts a load word this cycle.
REQ-010 Port reload  input  1  requests a new program load while running.
REQ-011 Port inst_address  input  32  is the CPU fetch byte address.
REQ-012 Port instruction  output  32  is the fetched instruction word returned to the CPU.
REQ-013 Port cpu_rst_n  output  1  is the active-low reset driven to the CPU core.
REQ-014 Port load_count  output  AW+1  is the number of words written by the last or current load.
REQ-015 Port fetch_err  output  1  is a sticky flag for misaligned or out-of-range fetches.

Function
REQ-016 The block SHALL implement states CLEAR, LOAD and RUN.
REQ-017 CLEAR SHALL write 32'h0 to one word per cycle at indices 0..DEPTH-1, then enter LOAD on the cycle after index DEPTH-1 is written (DEPTH cycles total).
REQ-018 In LOAD, load_ready SHALL be 1, and a beat SHALL be accepted exactly when load_valid and load_ready are both 1.
REQ-019 Each accepted beat SHALL write load_data to word index load_count[AW-1:0] and increment load_count by 1.
REQ-020 An accepted beat with load_last=1, or the beat that makes load_count equal DEPTH, SHALL move the state to RUN on the next cycle.
REQ-021 load_count SHALL saturate at DEPTH and never wrap.
REQ-022 In CLEAR and RUN, load_ready SHALL be 0, and load_valid SHALL be ignored.
REQ-023 cpu_rst_n SHALL be 1 only in RUN, registered, so the CPU leaves reset on the first RUN cycle.
REQ-024 In RUN, instruction SHALL equal mem[inst_address[AW+1:2]] combinationally, with zero-cycle latency, because the CPU samples it in the same cycle.
REQ-025 In CLEAR and LOAD, instruction SHALL be 32'h0 (the CPU no-op).
REQ-026 In RUN, an inst_address with bits [1:0] not equal to 0, or any bit above AW+1 set, SHALL return 32'h0 and set fetch_err on the next edge.
REQ-027 fetch_err SHALL hold until rst or until reload is accepted.
REQ-028 reload=1 in RUN SHALL, on the next edge, enter CLEAR, drive cpu_rst_n to 0, and clear load_count and fetch_err.
REQ-029 reload SHALL be ignored in CLEAR and LOAD.
REQ-030 If reload and a fetch error occur in the same cycle, reload SHALL take priority and fetch_err SHALL end at 0.

Reset
REQ-031 When rst=1, state SHALL become CLEAR and the clear index SHALL become 0.
REQ-032 When rst=1, load_count SHALL become 0, fetch_err 0, cpu_rst_n 0 and load_ready 0.
REQ-033 rst=1 during LOAD or RUN SHALL abort the load or execution and restart CLEAR; a partially loaded image is discarded.
REQ-034 Memory contents SHALL NOT be reset directly; they are zeroed only by CLEAR.

Structure
REQ-035 A shared package SHALL hold the state enumeration, DEPTH/AW defaults and the constant NOP_WORD = 32'h0.
REQ-036 Storage SHALL be one sub-module, imem_array, with one synchronous write port and one asynchronous read port.
REQ-037 The FSM, counters and address checking SHALL reside in imem_boot_loader.

Verification
REQ-038 DEPTH=256 -> rst then load 3 words 0x11111111, 0x22222222, 0x33333333 (last on the third) -> RUN after 256+3 cycles, cpu_rst_n=1, load_count=3, fetch 0x8 returns 0x33333333, fetch 0xC returns 0.
REQ-039 load_valid toggled 1,0,1 with load_ready=1 -> exactly 2 words written; the idle cycle writes nothing.
REQ-040 256 beats loaded without load_last -> RUN after beat 256, load_count=256, further load_valid ignored.
REQ-041 RUN fetch at 0x2 and at 0x400 -> instruction=0 both times, fetch_err=1 and held.
REQ-042 reload pulse in RUN -> next cycle CLEAR, cpu_rst_n=0, fetch_err=0; a new 1-word load replaces word 0 and old word 1 reads 0.
REQ-043 rst asserted mid-LOAD after 2 beats -> CLEAR, load_count=0, and no RUN entry until a full new load completes.

Source files
------------

// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_boot_loader_pkg;

  localparam int unsigned DEPTH_DEFAULT = 256;
  localparam int unsigned AW_DEFAULT    = 8;
  localparam int unsigned WORD_W        = 32;

  localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port, one asynchronous read port, no reset.
module imem_array
  import imem_boot_loader_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned AW    = AW_DEFAULT
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [WORD_W-1:0] rdata_c_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_c_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: zeroes instruction memory, accepts a program stream, then releases the CPU
// and serves zero-latency fetches with sticky misaligned/out-of-range error reporting.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned AW    = AW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [WORD_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              reload,
  input  logic [WORD_W-1:0] inst_address,
  output logic [WORD_W-1:0] instruction,
  output logic              cpu_rst_n,
  output logic [AW:0]       load_count,
  output logic              fetch_err
);

  localparam int unsigned CNT_W = AW + 1;

  state_e             state_q, state_d;
  logic [AW-1:0]      clr_idx_q, clr_idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ferr_q, ferr_d;
  logic               cpu_rst_n_q;

  logic               we_c;
  logic [AW-1:0]      waddr_c;
  logic [WORD_W-1:0]  wdata_c;
  logic [WORD_W-1:0]  rdata_c;
  logic               fetch_bad_c;

  // Misaligned or beyond the last word of the array.
  assign fetch_bad_c = (inst_address[1:0] != 2'b00) || ((inst_address >> (AW + 2)) != 32'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      clr_idx_q   <= '0;
      cnt_q       <= '0;
      ferr_q      <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      cnt_q       <= cnt_d;
      ferr_q      <= ferr_d;
      cpu_rst_n_q <= (state_d == ST_RUN);
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    cnt_d     = cnt_q;
    ferr_d    = ferr_q;
    we_c      = 1'b0;
    waddr_c   = '0;
    wdata_c   = NOP_WORD;

    case (state_q)
      ST_CLEAR: begin
        we_c      = 1'b1;
        waddr_c   = clr_idx_q;
        clr_idx_d = clr_idx_q + AW'(1);
        if (clr_idx_q == AW'(DEPTH - 1)) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (load_valid && (cnt_q != CNT_W'(DEPTH))) begin
          we_c    = 1'b1;
          waddr_c = cnt_q[AW-1:0];
          wdata_c = load_data;
          cnt_d   = cnt_q + CNT_W'(1);
          if (load_last || (cnt_q == CNT_W'(DEPTH - 1))) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // Reload wins over a simultaneous fetch error.
        if (reload) begin
          state_d   = ST_CLEAR;
          clr_idx_d = '0;
          cnt_d     = '0;
          ferr_d    = 1'b0;
        end else if (fetch_bad_c) begin
          ferr_d = 1'b1;
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_idx_d = '0;
      end
    endcase

    if (rst) begin
      we_c = 1'b0;
    end
  end

  imem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk       (clk),
    .we_i      (we_c),
    .waddr_i   (waddr_c),
    .wdata_i   (wdata_c),
    .raddr_i   (inst_address[AW+1:2]),
    .rdata_c_o (rdata_c)
  );

  assign instruction = ((state_q == ST_RUN) && !fetch_bad_c) ? rdata_c : NOP_WORD;
  assign load_ready  = (state_q == ST_LOAD);
  assign cpu_rst_n   = cpu_rst_n_q;
  assign load_count  = cnt_q;
  assign fetch_err   = ferr_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: fetch vectors through a scoreboard queue plus
// hand-written load/reload/reset sequences.
module tb_imem_boot_loader;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        reload;
  logic [31:0] inst_address;
  logic [31:0] instruction;
  logic        cpu_rst_n;
  logic [AW:0] load_count;
  logic        fetch_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
    logic        err;
  } fetch_vec_t;

  typedef struct {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  imem_boot_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_last    (load_last),
    .load_ready   (load_ready),
    .reload       (reload),
    .inst_address (inst_address),
    .instruction  (instruction),
    .cpu_rst_n    (cpu_rst_n),
    .load_count   (load_count),
    .fetch_err    (fetch_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_beat(input logic [31:0] data, input logic last);
    load_valid = 1'b1;
    load_data  = data;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_data  = 32'hDEAD_BEEF;
  endtask

  // Counts edges until the loader is ready for program data (bounded).
  task automatic wait_load(input string name, input int exp_cycles);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!load_ready && n < 600);
    check(name, 32'(n), 32'(exp_cycles));
  endtask

  // Scoreboarded fetch: expectation queued at drive time, popped when the DUT answers.
  task automatic fetch(input string name, input logic [31:0] addr,
                       input logic [31:0] exp_inst, input logic exp_err);
    exp_t e;
    e.inst = exp_inst;
    e.err  = exp_err;
    sb_q.push_back(e);
    inst_address = addr;
    @(negedge clk);
    e = sb_q.pop_front();
    check({name, "_inst"}, instruction, e.inst);
    tick();
    check({name, "_err"}, 32'(fetch_err), 32'(e.err));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic do_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  fetch_vec_t vecs[8];

  initial begin
    rst          = 1'b0;
    load_valid   = 1'b0;
    load_data    = 32'h0;
    load_last    = 1'b0;
    reload       = 1'b0;
    inst_address = 32'h0;

    vecs[0] = '{32'h0000_0000, 32'h1111_1111, 1'b0};
    vecs[1] = '{32'h0000_0004, 32'h2222_2222, 1'b0};
    vecs[2] = '{32'h0000_0008, 32'h3333_3333, 1'b0};
    vecs[3] = '{32'h0000_000C, 32'h0000_0000, 1'b0};
    vecs[4] = '{32'h0000_03FC, 32'h0000_0000, 1'b0};
    vecs[5] = '{32'h0000_0002, 32'h0000_0000, 1'b1};
    vecs[6] = '{32'h0000_0004, 32'h2222_2222, 1'b1};
    vecs[7] = '{32'h0000_0400, 32'h0000_0000, 1'b1};

    // Reset state and the 3-word boot.
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("rst_load_ready", 32'(load_ready), 32'd0);
    check("rst_load_count", 32'(load_count), 32'd0);
    check("rst_fetch_err", 32'(fetch_err), 32'd0);
    check("rst_instruction", instruction, 32'h0);
    tick();
    rst = 1'b0;
    wait_load("clear_cycles_boot", 256);
    check("load_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    load_beat(32'h1111_1111, 1'b0);
    check("load_count_1", 32'(load_count), 32'd1);
    load_beat(32'h2222_2222, 1'b0);
    load_beat(32'h3333_3333, 1'b1);
    check("run_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    check("run_load_ready", 32'(load_ready), 32'd0);
    check("run_load_count", 32'(load_count), 32'd3);

    // Fetch table; load_valid held high in RUN must be ignored.
    load_valid = 1'b1;
    load_data  = 32'hBAD0_BAD0;
    for (int i = 0; i < 8; i++) begin
      fetch($sformatf("vec%0d", i), vecs[i].addr, vecs[i].inst, vecs[i].err);
    end
    load_valid = 1'b0;
    check("run_ignores_load", 32'(load_count), 32'd3);

    // Reload coinciding with a misaligned fetch: reload wins.
    inst_address = 32'h0000_0001;
    reload = 1'b1;
    tick();
    check("reload_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("reload_fetch_err", 32'(fetch_err), 32'd0);
    check("reload_load_count", 32'(load_count), 32'd0);
    check("reload_load_ready", 32'(load_ready), 32'd0);
    check("reload_instruction", instruction, 32'h0);
    // Reload stays asserted through CLEAR and must not restart it.
    wait_load("clear_cycles_reload", 256);
    reload = 1'b0;
    check("load_instruction_nop", instruction, 32'h0);
    load_beat(32'hCAFE_F00D, 1'b1);
    check("one_word_count", 32'(load_count), 32'd1);
    fetch("one_w0", 32'h0, 32'hCAFE_F00D, 1'b0);
    fetch("one_w1", 32'h4, 32'h0, 1'b0);

    // valid 1,0,1: only two words land.
    do_reload();
    wait_load("clear_cycles_toggle", 256);
    load_beat(32'hAAAA_0000, 1'b0);
    load_data = 32'h5555_5555;
    tick();
    check("idle_count", 32'(load_count), 32'd1);
    check("idle_still_loading", 32'(load_ready), 32'd1);
    load_beat(32'hBBBB_0001, 1'b1);
    check("toggle_count", 32'(load_count), 32'd2);
    fetch("tog_w0", 32'h0, 32'hAAAA_0000, 1'b0);
    fetch("tog_w1", 32'h4, 32'hBBBB_0001, 1'b0);
    fetch("tog_w2", 32'h8, 32'h0, 1'b0);

    // Full image without load_last.
    do_reload();
    wait_load("clear_cycles_full", 256);
    for (int i = 0; i < 255; i++) begin
      load_beat(32'h1000_0000 | 32'(i), 1'b0);
    end
    check("full_ready_255", 32'(load_ready), 32'd1);
    check("full_count_255", 32'(load_count), 32'd255);
    load_beat(32'h1000_00FF, 1'b0);
    check("full_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    check("full_count", 32'(load_count), 32'd256);
    load_valid = 1'b1;
    tick();
    tick();
    load_valid = 1'b0;
    check("full_count_sat", 32'(load_count), 32'd256);
    fetch("full_w255", 32'h3FC, 32'h1000_00FF, 1'b0);
    fetch("full_w0", 32'h0, 32'h1000_0000, 1'b0);

    // Reset mid-load discards the partial image.
    do_reset();
    wait_load("clear_cycles_rst1", 256);
    load_beat(32'h7777_0000, 1'b0);
    load_beat(32'h7777_0001, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_ready", 32'(load_ready), 32'd0);
    check("midrst_count", 32'(load_count), 32'd0);
    check("midrst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    wait_load("clear_cycles_rst2", 256);
    check("midrst_no_run", 32'(cpu_rst_n), 32'd0);
    load_beat(32'h9999_0000, 1'b1);
    check("midrst_run", 32'(cpu_rst_n), 32'd1);
    fetch("midrst_w0", 32'h0, 32'h9999_0000, 1'b0);
    fetch("midrst_w1", 32'h4, 32'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
